mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/arm_pkg.sv | 13 +
 rtl/mem_wb_stage_reg.sv | 38 +++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared datapath constants and MEM-stage FSM state encoding for the ARM pipeline.
package arm_pkg;

    localparam int BIT_NUMBER = 32;
    localparam int MEM_BASE   = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: plain async-reset flops, one-edge latency.
// No backpressure of its own; the parent presents bubble or hold values on the d side.
module mem_wb_stage_reg
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER = arm_pkg::BIT_NUMBER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_d,
    input  logic                  mem_r_en_d,
    input  logic [BIT_NUMBER-1:0] alu_result_d,
    input  logic [BIT_NUMBER-1:0] mem_data_d,
    input  logic [3:0]            dest_d,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic [BIT_NUMBER-1:0] alu_result,
    output logic [BIT_NUMBER-1:0] mem_data,
    output logic [3:0]            dest
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            alu_result <= '0;
            mem_data   <= '0;
            dest       <= 4'd0;
        end else begin
            wb_en      <= wb_en_d;
            mem_r_en   <= mem_r_en_d;
            alu_result <= alu_result_d;
            mem_data   <= mem_data_d;
            dest       <= dest_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage with req/ack data-memory port; memory op acked on ACCESS cycle k lands in MEM/WB k+2 edges after issue.
// Backpressure: freeze stalls PC and IF/ID/EXE from op presentation until the DONE cycle.
module mem_stage
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER = arm_pkg::BIT_NUMBER,
    parameter int ADDR_W     = 16,
    parameter int MEM_BASE   = arm_pkg::MEM_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [BIT_NUMBER-1:0] alu_result_in,
    input  logic [BIT_NUMBER-1:0] val_rm_in,
    input  logic [3:0]            dest_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BIT_NUMBER-1:0] mem_wdata,
    input  logic [BIT_NUMBER-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  freeze,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic [BIT_NUMBER-1:0] alu_result,
    output logic [BIT_NUMBER-1:0] mem_data,
    output logic [3:0]            dest
);

    mem_state_t state_q;
    mem_state_t state_d;

    logic                  op_in;
    logic                  freeze_raw;
    logic [BIT_NUMBER-1:0] byte_off;
    logic [ADDR_W-1:0]     word_addr;
    logic [BIT_NUMBER-1:0] rdata_q;

    logic                  wb_en_d;
    logic                  mem_r_en_d;
    logic [BIT_NUMBER-1:0] alu_result_d;
    logic [BIT_NUMBER-1:0] mem_data_d;
    logic [3:0]            dest_d;

    assign op_in = mem_r_en_in | mem_w_en_in;

    // Low two byte-address bits drop out in the shift; the window wraps modulo 2^ADDR_W.
    assign byte_off  = alu_result_in - BIT_NUMBER'(MEM_BASE);
    assign word_addr = ADDR_W'(byte_off >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_in)   state_d = ACCESS;
            ACCESS:  if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        freeze_raw   = 1'b0;
        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        alu_result_d = alu_result;
        mem_data_d   = mem_data;
        dest_d       = dest;
        case (state_q)
            IDLE: begin
                if (op_in) begin
                    freeze_raw = 1'b1;
                end else begin
                    wb_en_d      = wb_en_in;
                    mem_r_en_d   = mem_r_en_in;
                    alu_result_d = alu_result_in;
                    mem_data_d   = '0;
                    dest_d       = dest_in;
                end
            end
            ACCESS: begin
                mem_req    = 1'b1;
                freeze_raw = 1'b1;
            end
            DONE: begin
                wb_en_d      = wb_en_in;
                mem_r_en_d   = mem_r_en_in;
                alu_result_d = alu_result_in;
                mem_data_d   = rdata_q;
                dest_d       = dest_in;
            end
            default: begin
                freeze_raw = 1'b0;
            end
        endcase
    end

    // Reset parks the FSM in IDLE, where a held EXE op would otherwise raise freeze.
    assign freeze = freeze_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == IDLE && op_in) begin
                mem_we    <= mem_w_en_in & ~mem_r_en_in;
                mem_addr  <= word_addr;
                mem_wdata <= val_rm_in;
            end
            if (state_q == ACCESS && mem_ack) begin
                rdata_q <= mem_we ? '0 : mem_rdata;
            end
        end
    end

    mem_wb_stage_reg #(
        .BIT_NUMBER(BIT_NUMBER)
    ) u_mem_wb (
        .clk         (clk),
        .rst         (rst),
        .wb_en_d     (wb_en_d),
        .mem_r_en_d  (mem_r_en_d),
        .alu_result_d(alu_result_d),
        .mem_data_d  (mem_data_d),
        .dest_d      (dest_d),
        .wb_en       (wb_en),
        .mem_r_en    (mem_r_en),
        .alu_result  (alu_result),
        .mem_data    (mem_data),
        .dest        (dest)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-feature tasks with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, val_rm_in;
    logic [3:0]  dest_in;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        freeze, wb_en, mem_r_en;
    logic [31:0] alu_result, mem_data;
    logic [3:0]  dest;

    int n_cmp = 0;
    int n_fail = 0;

    mem_stage #(.BIT_NUMBER(32), .ADDR_W(16), .MEM_BASE(1024)) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
        .mem_data(mem_data), .dest(dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic w, input logic r, input logic s, input logic [31:0] a,
                          input logic [31:0] v, input logic [3:0] d);
        wb_en_in = w; mem_r_en_in = r; mem_w_en_in = s;
        alu_result_in = a; val_rm_in = v; dest_in = d;
    endtask

    // Memory responder: acks on the k-th cycle it sees mem_req, over ncyc cycles, counting freeze/req.
    task automatic run_op(input int k, input logic [31:0] rdata, input int ncyc,
                          output int fz, output int rq,
                          output logic [15:0] a_first, output logic [15:0] a_last,
                          output logic we_first, output logic we_last,
                          output logic [31:0] wd_first, output logic [31:0] wd_last,
                          output logic wb1, output logic [31:0] alu1);
        int seen;
        fz = 0; rq = 0; seen = 0;
        a_first = '0; a_last = '0; we_first = 1'b0; we_last = 1'b0;
        wd_first = '0; wd_last = '0; wb1 = 1'b0; alu1 = '0;
        for (int c = 0; c < ncyc; c++) begin
            mem_ack = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            if (mem_req) begin
                seen++;
                if (seen == 1) begin a_first = mem_addr; we_first = mem_we; wd_first = mem_wdata; end
                a_last = mem_addr; we_last = mem_we; wd_last = mem_wdata;
                if (seen == k) begin mem_ack = 1'b1; mem_rdata = rdata; end
            end
            #1;
            if (freeze) fz++;
            if (mem_req) rq++;
            @(posedge clk); #1;
            if (c == 0) begin wb1 = wb_en; alu1 = alu_result; end
        end
        mem_ack = 1'b0;
    endtask

    int fz, rq;
    logic [15:0] af, al;
    logic wf, wl, wb1;
    logic [31:0] df, dl, alu1;

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        set_in(1'b1, 1'b1, 1'b0, 32'd1024, 32'h77, 4'd6);
        @(posedge clk); #1; @(posedge clk); #1;
        n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %h want 0", freeze); end
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
        n_cmp++; if (wb_en !== 1'b0 || alu_result !== 32'h0 || dest !== 4'h0) begin n_fail++; $display("FAIL reset_memwb: wb=%h alu=%h dest=%h want 0", wb_en, alu_result, dest); end
        n_cmp++; if (mem_addr !== 16'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_port: addr=%h we=%h wd=%h want 0", mem_addr, mem_we, mem_wdata); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_non_mem();
        set_in(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        #1;
        n_cmp++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL nonmem_freeze_pre: got %h want 0", freeze); end
        @(posedge clk); #1;
        n_cmp++; if (freeze !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL nonmem_freeze_post: freeze=%h req=%h want 0", freeze, mem_req); end
        n_cmp++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL nonmem_wb_en: got %h want 1", wb_en); end
        n_cmp++; if (alu_result !== 32'h55) begin n_fail++; $display("FAIL nonmem_alu: got %h want 55", alu_result); end
        n_cmp++; if (dest !== 4'd3 || mem_data !== 32'h0) begin n_fail++; $display("FAIL nonmem_dest_data: dest=%h data=%h want 3/0", dest, mem_data); end
    endtask

    task automatic test_store();
        set_in(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD, 4'd4);
        run_op(3, 32'h0BAD_F00D, 5, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (fz !== 4) begin n_fail++; $display("FAIL store_freeze_cycles: got %0d want 4", fz); end
        n_cmp++; if (rq !== 3) begin n_fail++; $display("FAIL store_req_cycles: got %0d want 3", rq); end
        n_cmp++; if (af !== 16'd2 || al !== 16'd2) begin n_fail++; $display("FAIL store_addr: first=%h last=%h want 2", af, al); end
        n_cmp++; if (wf !== 1'b1 || wl !== 1'b1) begin n_fail++; $display("FAIL store_we: first=%h last=%h want 1", wf, wl); end
        n_cmp++; if (df !== 32'hDEAD || dl !== 32'hDEAD) begin n_fail++; $display("FAIL store_wdata: first=%h last=%h want dead", df, dl); end
        n_cmp++; if (wb1 !== 1'b0 || alu1 !== 32'h55) begin n_fail++; $display("FAIL store_bubble: wb=%h alu=%h want 0/55", wb1, alu1); end
        n_cmp++; if (wb_en !== 1'b0 || mem_r_en !== 1'b0 || mem_data !== 32'h0) begin n_fail++; $display("FAIL store_memwb_ctl: wb=%h r=%h data=%h want 0/0/0", wb_en, mem_r_en, mem_data); end
        n_cmp++; if (alu_result !== 32'd1032 || dest !== 4'd4) begin n_fail++; $display("FAIL store_memwb_data: alu=%h dest=%h want 408/4", alu_result, dest); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_load();
        set_in(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd5);
        run_op(1, 32'h1234, 3, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (fz !== 2 || rq !== 1) begin n_fail++; $display("FAIL load_cycles: freeze=%0d req=%0d want 2/1", fz, rq); end
        n_cmp++; if (af !== 16'd0 || wf !== 1'b0) begin n_fail++; $display("FAIL load_port: addr=%h we=%h want 0/0", af, wf); end
        n_cmp++; if (wb1 !== 1'b0 || alu1 !== 32'd1032) begin n_fail++; $display("FAIL load_bubble: wb=%h alu=%h want 0/408", wb1, alu1); end
        n_cmp++; if (wb_en !== 1'b1 || mem_r_en !== 1'b1) begin n_fail++; $display("FAIL load_memwb_ctl: wb=%h r=%h want 1/1", wb_en, mem_r_en); end
        n_cmp++; if (mem_data !== 32'h1234 || alu_result !== 32'd1024 || dest !== 4'd5) begin n_fail++; $display("FAIL load_memwb_data: data=%h alu=%h dest=%h want 1234/400/5", mem_data, alu_result, dest); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_both_enables();
        set_in(1'b1, 1'b1, 1'b1, 32'd1028, 32'h5A5A, 4'd7);
        run_op(2, 32'hCAFE, 4, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (wf !== 1'b0 || wl !== 1'b0) begin n_fail++; $display("FAIL both_we: first=%h last=%h want 0", wf, wl); end
        n_cmp++; if (af !== 16'd1) begin n_fail++; $display("FAIL both_addr: got %h want 1", af); end
        n_cmp++; if (fz !== 3 || rq !== 2) begin n_fail++; $display("FAIL both_cycles: freeze=%0d req=%0d want 3/2", fz, rq); end
        n_cmp++; if (mem_data !== 32'hCAFE || mem_r_en !== 1'b1 || dest !== 4'd7) begin n_fail++; $display("FAIL both_memwb: data=%h r=%h dest=%h want cafe/1/7", mem_data, mem_r_en, dest); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_addr_wrap();
        set_in(1'b0, 1'b0, 1'b1, 32'd1020, 32'h1, 4'd8);
        run_op(1, 32'h0, 3, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (af !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr: got %h want ffff", af); end
        set_in(1'b1, 1'b1, 1'b0, 32'd1027, 32'h0, 4'd9);
        run_op(1, 32'h600D, 3, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (af !== 16'h0000) begin n_fail++; $display("FAIL lowbits_addr: got %h want 0", af); end
        n_cmp++; if (mem_data !== 32'h600D) begin n_fail++; $display("FAIL lowbits_data: got %h want 600d", mem_data); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd1);
        run_op(1, 32'h1111, 3, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (rq !== 1 || af !== 16'd2) begin n_fail++; $display("FAIL b2b_a_req: req=%0d addr=%h want 1/2", rq, af); end
        n_cmp++; if (mem_data !== 32'h1111 || dest !== 4'd1) begin n_fail++; $display("FAIL b2b_a_memwb: data=%h dest=%h want 1111/1", mem_data, dest); end
        set_in(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd2);
        run_op(1, 32'h2222, 3, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (rq !== 1 || fz !== 2 || af !== 16'd3) begin n_fail++; $display("FAIL b2b_b_req: req=%0d freeze=%0d addr=%h want 1/2/3", rq, fz, af); end
        n_cmp++; if (mem_data !== 32'h2222 || dest !== 4'd2 || wb_en !== 1'b1) begin n_fail++; $display("FAIL b2b_b_memwb: data=%h dest=%h wb=%h want 2222/2/1", mem_data, dest, wb_en); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: req=%h freeze=%h want 0/0", mem_req, freeze); end
    endtask

    task automatic test_reset_mid_access();
        set_in(1'b1, 1'b1, 1'b0, 32'd1040, 32'h99, 4'd9);
        #1;
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'd4) begin n_fail++; $display("FAIL rstmid_in_access: req=%h addr=%h want 1/4", mem_req, mem_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_freeze: req=%h freeze=%h want 0/0", mem_req, freeze); end
        n_cmp++; if (wb_en !== 1'b0 || mem_r_en !== 1'b0 || alu_result !== 32'h0 || mem_data !== 32'h0 || dest !== 4'h0) begin n_fail++; $display("FAIL rstmid_memwb: wb=%h r=%h alu=%h data=%h dest=%h want 0", wb_en, mem_r_en, alu_result, mem_data, dest); end
        n_cmp++; if (mem_addr !== 16'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_port: addr=%h we=%h wd=%h want 0", mem_addr, mem_we, mem_wdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || freeze !== 1'b0 || mem_data !== 32'h0) begin n_fail++; $display("FAIL stray_ack: req=%h freeze=%h data=%h want 0/0/0", mem_req, freeze, mem_data); end
        set_in(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd10);
        run_op(2, 32'h4242, 4, fz, rq, af, al, wf, wl, df, dl, wb1, alu1);
        n_cmp++; if (fz !== 3 || rq !== 2 || af !== 16'd6) begin n_fail++; $display("FAIL post_rst_load: freeze=%0d req=%0d addr=%h want 3/2/6", fz, rq, af); end
        n_cmp++; if (mem_data !== 32'h4242 || dest !== 4'd10) begin n_fail++; $display("FAIL post_rst_memwb: data=%h dest=%h want 4242/a", mem_data, dest); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_store();
        test_load();
        test_both_enables();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
